// File: rtl/alu64bit_seq.sv
// Sliced 64-bit ALU (NOR/XOR/ADD/SUB), SLICE_W bits per clock, N=64/SLICE_W clocks accept-to-out_valid; holds result under out_ready=0.
// Optional signed-overflow output ovf is built only when ALU_SEQ_OVF_EN is defined.
module alu64bit_seq #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  input  logic [1:0]  op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] s,
  output logic        cout
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int         N    = 64 / SLICE_W;
  localparam logic [6:0] LAST = 7'(N - 1);

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } req_t;

  state_t             state_q, state_d;
  req_t               req_q;
  logic               carry_q;
  logic [6:0]         cnt_q;
  logic [63:0]        acc_q;
  logic [63:0]        acc_d;
  logic               accept;
  logic               last_slice;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_r;
  logic [SLICE_W:0]   slice_sum;
  logic               slice_c;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign accept     = in_valid && in_ready;
  assign last_slice = (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last_slice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are shifted right each slice, so the current slice always sits in the low bits.
  always_comb begin
    slice_a   = req_q.a[SLICE_W-1:0];
    slice_b   = (req_q.op == OP_SUB) ? ~req_q.b[SLICE_W-1:0] : req_q.b[SLICE_W-1:0];
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + (SLICE_W+1)'(carry_q);
    slice_r   = '0;
    slice_c   = 1'b0;
    case (req_q.op)
      OP_NOR:  slice_r = ~(slice_a | slice_b);
      OP_XOR:  slice_r = slice_a ^ slice_b;
      default: begin
        slice_r = slice_sum[SLICE_W-1:0];
        slice_c = slice_sum[SLICE_W];
      end
    endcase
    // Result bits enter at the top and move down, landing in place after the last slice.
    acc_d = (acc_q >> SLICE_W) | (64'(slice_r) << (64 - SLICE_W));
  end

`ifdef ALU_SEQ_OVF_EN
  logic slice_ovf;

  // Carry into bit 63 is recovered from the MSB sum bit: c_in = a ^ b ^ sum.
  always_comb begin
    slice_ovf = 1'b0;
    if (req_q.op == OP_ADD || req_q.op == OP_SUB) begin
      slice_ovf = slice_c ^ (slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_r[SLICE_W-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state_q == CALC && last_slice) begin
      ovf <= slice_ovf;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      s       <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q.op <= op;
            req_q.a  <= a;
            req_q.b  <= b;
            carry_q  <= (op == OP_ADD) ? cin : (op == OP_SUB);
            cnt_q    <= '0;
          end
        end
        CALC: begin
          req_q.a <= req_q.a >> SLICE_W;
          req_q.b <= req_q.b >> SLICE_W;
          carry_q <= slice_c;
          cnt_q   <= cnt_q + 7'd1;
          acc_q   <= acc_d;
          if (last_slice) begin
            s    <= acc_d;
            cout <= slice_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
